sha3_padder: RTL and testbench
==============================

Name: sha3_padder

Overview:
- Upstream stage of `keccak`. Accepts the message as a byte stream over a valid/ready handshake.
- Packs bytes into r-bit rate blocks and applies SHA-3 multi-rate padding (domain suffix 0x06, final bit 0x80).
- Presents each block to the permutation core with valid/ready and a last-block flag. It replaces bench-side file padding with synthesizable logic.

Parameters:
- d, 256, digest width in bits; must be 224, 256, 384 or 512.
- r, 1600-2*d, rate in bits (1088 for d=256); R = r/8 bytes per block.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  8  message byte.
- in_valid  in  1  in_data/in_last/in_empty valid.
- in_last  in  1  current transfer ends the message.
- in_empty  in  1  with in_last: transfer carries no data byte (zero-length tail); ignored when in_last=0.
- in_ready  out  1  block accepts a transfer this cycle.
- block  out  r  padded rate block; byte k at block[8k+7:8k]; first message byte at byte 0.
- block_valid  out  1  block holds a complete block.
- block_last  out  1  block is the final padded block of the message.
- block_ready  in  1  consumer takes block this cycle.

Behaviour:
- Reset:
  - block, block_valid, block_last and the byte counter are 0.
  - State is FILL, so in_ready=1 in the first cycle after reset is deasserted.
  - Reset asserted mid-message or mid-handshake discards all partial and pending data; no block is emitted.
- Transfers: an input transfer occurs when in_valid & in_ready; an output transfer occurs when block_valid & block_ready.
- Byte counter cnt: $clog2(R) bits, range 0..R-1.
- FILL (in_ready=1, block_valid=0):
  - Data transfer, in_last=0: store in_data at byte cnt, cnt++.
  - If cnt was R-1: go to HOLD with block_last=0 and cnt=0.
  - Data transfer, in_last=1, in_empty=0: store the byte at cnt, then pad from p=cnt+1.
  - Transfer with in_last=1, in_empty=1: pad from p=cnt.
- Padding from p:
  - If p<R: byte p |= 0x06, bytes p+1..R-1 = 0x00, byte R-1 |= 0x80. If p=R-1 this yields 0x86. Go to HOLD with block_last=1.
  - If p=R (last byte filled the block): go to HOLD with block_last=0 and set pad_pending.
- HOLD (in_ready=0, block_valid=1):
  - block and block_last stay stable until an output transfer.
  - On output transfer with pad_pending: go to EXTRA.
  - Otherwise: clear block and go to FILL with cnt=0.
- EXTRA (in_ready=0, block_valid=1):
  - Presents byte 0=0x06, byte R-1=0x80, all others 0, with block_last=1.
  - On output transfer: clear pad_pending, go to FILL.
- Latency: block_valid rises the cycle after the completing input transfer. Throughput is one byte per cycle plus at least 1 cycle per block for the handshake.
- in_ready is purely a function of state. No combinational path from block_ready to in_ready.
- Messages may be back-to-back: the first byte of the next message is accepted in the first FILL cycle after the final output transfer.
- Bytes presented while in_ready=0 are not consumed; the upstream source must hold them.

Optional Feature:
- Macro SHA3_PADDER_SHAKE_EN.
- Defined: adds input port xof (1 bit), sampled on the in_last transfer. When xof=1, the domain suffix byte is 0x1F instead of 0x06, for SHAKE128/256. The combined single-byte case becomes 0x9F, and the EXTRA block byte 0 becomes 0x1F.
- Undefined: no xof port; suffix fixed at 0x06.

Test Plan:
- d=256, reset, then a single transfer in_last=1, in_empty=1:
  - Expect one block with byte0=0x06, byte135=0x80, rest 0.
  - block_last=1; block_valid rises one cycle after the transfer.
- "abc" (0x61, 0x62, 0x63, last on 0x63), block_ready=1:
  - Expect bytes 0..3 = 61 62 63 06, bytes 4..134 = 00, byte135 = 80, block_last=1.
  - The block fed through keccak yields digest 3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532.
- 135-byte message:
  - Expect a single block with byte135=0x86, block_last=1.
- 136-byte message of 0xA5:
  - Expect block 1 all 0xA5 with block_last=0, then block 2 = 06, 00…00, 80 with block_last=1.
  - in_ready=0 across both blocks.
- Backpressure: hold block_ready=0 for 5 cycles after block_valid:
  - block and block_last are bit-stable and in_ready=0 throughout.
  - Exactly one output transfer occurs when block_ready rises.
- Reset mid-block after 50 bytes, then send "abc":
  - No block emitted before the reset.
  - The following block equals the "abc" result above, with no stale bytes.

Source files
------------

// File: rtl/sha3_padder.sv
// SHA-3 input padder: packs a byte stream into r-bit rate blocks and applies multi-rate padding.
// Define SHA3_PADDER_SHAKE_EN to add the xof input that selects the SHAKE domain suffix (0x1F).
module sha3_padder #(
    parameter int d = 256,
    parameter int r = 1600 - 2*d
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic         in_empty,
`ifdef SHA3_PADDER_SHAKE_EN
    input  logic         xof,
`endif
    output logic         in_ready,
    output logic [r-1:0] block,
    output logic         block_valid,
    output logic         block_last,
    input  logic         block_ready
);

    localparam int R  = r / 8;
    localparam int CW = $clog2(R);

    typedef enum logic [1:0] {FILL, HOLD, EXTRA} state_t;

    state_t        state, state_n;
    logic [r-1:0]  block_n;
    logic          last_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          pad_pending, pad_pending_n;
    logic [7:0]    sfx_q, sfx_n, sfx_in;
    logic          is_data;
    int            idx;
    int            p;

`ifdef SHA3_PADDER_SHAKE_EN
    assign sfx_in = xof ? 8'h1F : 8'h06;
`else
    assign sfx_in = 8'h06;
`endif

    assign in_ready    = (state == FILL);
    assign block_valid = (state != FILL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FILL;
            block       <= '0;
            block_last  <= 1'b0;
            cnt         <= '0;
            pad_pending <= 1'b0;
            sfx_q       <= 8'h06;
        end else begin
            state       <= state_n;
            block       <= block_n;
            block_last  <= last_n;
            cnt         <= cnt_n;
            pad_pending <= pad_pending_n;
            sfx_q       <= sfx_n;
        end
    end

    // Bytes above the fill point are always zero (cleared on block hand-off),
    // so padding only needs to OR in the suffix byte and the final 0x80 bit.
    always_comb begin
        state_n       = state;
        block_n       = block;
        last_n        = block_last;
        cnt_n         = cnt;
        pad_pending_n = pad_pending;
        sfx_n         = sfx_q;
        idx           = int'(cnt);
        is_data       = !(in_last && in_empty);
        p             = is_data ? idx + 1 : idx;

        case (state)
            FILL: begin
                if (in_valid) begin
                    for (int k = 0; k < R; k++) begin
                        if (is_data && k == idx) block_n[8*k +: 8] = in_data;
                    end
                    if (in_last) begin
                        sfx_n   = sfx_in;
                        state_n = HOLD;
                        cnt_n   = '0;
                        if (p < R) begin
                            for (int k = 0; k < R; k++) begin
                                if (k == p) block_n[8*k +: 8] = block_n[8*k +: 8] | sfx_in;
                            end
                            block_n[r-8 +: 8] = block_n[r-8 +: 8] | 8'h80;
                            last_n = 1'b1;
                        end else begin
                            pad_pending_n = 1'b1;
                            last_n        = 1'b0;
                        end
                    end else if (idx == R - 1) begin
                        state_n = HOLD;
                        last_n  = 1'b0;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (block_ready) begin
                    block_n = '0;
                    cnt_n   = '0;
                    if (pad_pending) begin
                        // Message ended exactly on a block boundary: a padding-only block follows.
                        state_n           = EXTRA;
                        block_n[7:0]      = sfx_q;
                        block_n[r-8 +: 8] = 8'h80;
                        last_n            = 1'b1;
                    end else begin
                        state_n = FILL;
                        last_n  = 1'b0;
                    end
                end
            end
            EXTRA: begin
                if (block_ready) begin
                    state_n       = FILL;
                    block_n       = '0;
                    last_n        = 1'b0;
                    pad_pending_n = 1'b0;
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase
    end

endmodule

// File: tb/tb_sha3_padder.sv
// Self-checking bench for sha3_padder: directed cases plus randomized messages against a padding model.
module tb_sha3_padder;

    localparam int D  = 256;
    localparam int RB = 1600 - 2*D;
    localparam int R  = RB / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_empty;
    logic          in_ready;
    logic [RB-1:0] block;
    logic          block_valid;
    logic          block_last;
    logic          block_ready;
`ifdef SHA3_PADDER_SHAKE_EN
    logic          xof = 1'b0;
`endif

    int            asserts = 0;
    int            fails   = 0;
    logic [7:0]    msg_q[$];
    logic [RB-1:0] exp_blk[$];
    logic          exp_last[$];

    sha3_padder #(.d(D)) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_empty(in_empty),
`ifdef SHA3_PADDER_SHAKE_EN
        .xof(xof),
`endif
        .in_ready(in_ready),
        .block(block),
        .block_valid(block_valid),
        .block_last(block_last),
        .block_ready(block_ready)
    );

    always #5 clk = ~clk;

    // Reference: padded length is the smallest multiple of R that holds the message plus one suffix byte.
    task automatic buildExpected();
        int len   = msg_q.size();
        int total = ((len / R) + 1) * R;
        logic [7:0] padded[$];
        logic [RB-1:0] blk;
        for (int i = 0; i < total; i++) padded.push_back(i < len ? msg_q[i] : 8'h00);
        padded[len]     = padded[len] | 8'h06;
        padded[total-1] = padded[total-1] | 8'h80;
        exp_blk.delete();
        exp_last.delete();
        for (int b = 0; b < total / R; b++) begin
            blk = '0;
            for (int k = R - 1; k >= 0; k--) blk = {blk[RB-9:0], padded[b*R + k]};
            exp_blk.push_back(blk);
            exp_last.push_back(b == total / R - 1);
        end
    endtask

    function automatic int firstDiff(input logic [RB-1:0] a, input logic [RB-1:0] b);
        logic [RB-1:0] x = a ^ b;
        for (int k = 0; k < R; k++) begin
            if (x[7:0] !== 8'h00) return k;
            x = x >> 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] byteOf(input logic [RB-1:0] v, input int k);
        logic [RB-1:0] s = v >> (8 * k);
        return s[7:0];
    endfunction

    task automatic checkBit(input string tag, input logic got, input logic exp);
        asserts++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic checkBlock(input string tag, input logic [RB-1:0] got, input logic [RB-1:0] exp);
        int k;
        asserts++;
        assert (got === exp) else begin
            fails++;
            k = firstDiff(got, exp);
            $error("[TB] FAIL %s: byte %0d got %h expected %h", tag, k, byteOf(got, k), byteOf(exp, k));
        end
    endtask

    task automatic checkOutput(input int n);
        checkBlock($sformatf("block%0d_data", n), block, exp_blk[n]);
        checkBit($sformatf("block%0d_last", n), block_last, exp_last[n]);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
        in_data = 8'h00; block_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checkBit("reset_in_ready", in_ready, 1'b1);
        checkBit("reset_block_valid", block_valid, 1'b0);
        checkBit("reset_block_last", block_last, 1'b0);
        checkBlock("reset_block", block, '0);
    endtask

    // Streams msg_q in with random input gaps and output backpressure, checking every block.
    task automatic applyStimulus(input int gap_pct, input int bp_pct);
        int items = (msg_q.size() == 0) ? 1 : msg_q.size();
        int sent = 0, got = 0, cycles = 0;
        bit expect_valid = 1'b0;
        buildExpected();
        while (got < exp_blk.size() && cycles < 20000) begin
            @(negedge clk);
            if (expect_valid) begin
                checkBit("latency_block_valid", block_valid, 1'b1);
                expect_valid = 1'b0;
            end
            if (block_valid) checkBit("in_ready_while_holding", in_ready, 1'b0);
            in_valid    = (sent < items) && ($urandom_range(99) >= gap_pct);
            in_data     = (sent < msg_q.size()) ? msg_q[sent] : 8'h00;
            in_last     = (sent == items - 1);
            in_empty    = (msg_q.size() == 0);
            block_ready = ($urandom_range(99) >= bp_pct);
            if (block_valid && block_ready) begin
                checkOutput(got);
                got++;
            end
            if (in_valid && in_ready) begin
                if (in_last || ((sent + 1) % R == 0)) expect_valid = 1'b1;
                sent++;
            end
            cycles++;
        end
        asserts++;
        assert (got == exp_blk.size()) else begin
            fails++;
            $error("[TB] FAIL block_count: got %0d expected %0d", got, exp_blk.size());
        end
        @(negedge clk);
        in_valid = 1'b0; block_ready = 1'b0;
        checkBit("idle_block_valid", block_valid, 1'b0);
        checkBit("idle_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
        in_data = 8'h00; block_ready = 1'b0;
        doReset();

        $display("[TB] empty message");
        msg_q.delete();
        applyStimulus(0, 0);

        $display("[TB] abc");
        msg_q = '{8'h61, 8'h62, 8'h63};
        applyStimulus(0, 0);

        $display("[TB] 135-byte message");
        msg_q.delete();
        for (int i = 0; i < R - 1; i++) msg_q.push_back(8'($urandom));
        applyStimulus(0, 0);

        $display("[TB] 136 bytes of A5");
        msg_q.delete();
        for (int i = 0; i < R; i++) msg_q.push_back(8'hA5);
        applyStimulus(0, 0);

        $display("[TB] backpressure on abc");
        msg_q = '{8'h61, 8'h62, 8'h63};
        buildExpected();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkBit("bp_in_ready", in_ready, 1'b1);
            in_valid = 1'b1; in_data = msg_q[i]; in_last = (i == 2); in_empty = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checkBit("bp_block_valid", block_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput(0);
            checkBit("bp_hold_in_ready", in_ready, 1'b0);
            checkBit("bp_hold_valid", block_valid, 1'b1);
        end
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkBit("bp_single_transfer", block_valid, 1'b0);
            @(negedge clk);
        end

        $display("[TB] reset mid-block");
        block_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checkBit("partial_no_block", block_valid, 1'b0);
            in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0; in_empty = 1'b0;
        end
        doReset();
        msg_q = '{8'h61, 8'h62, 8'h63};
        applyStimulus(0, 0);

        $display("[TB] randomized messages");
        for (int t = 0; t < 8; t++) begin
            int len;
            case (t)
                0: len = 1;
                1: len = R + 1;
                2: len = 2*R - 1;
                3: len = 2*R;
                default: len = $urandom_range(0, 3*R);
            endcase
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
            applyStimulus(30, 30);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
